// File: rtl/kernel_run_sequencer_if.sv
// rtl/kernel_run_sequencer_if.sv - kernel start/done handshake plus result record stream
interface kernel_run_sequencer_if #(
    parameter int RUN_W   = 8,
    parameter int CYCLE_W = 32
);
    logic               start_port;
    logic               done_port;
    logic               compare_ok;
    logic               res_valid;
    logic               res_ready;
    logic [1:0]         res_status;
    logic [CYCLE_W-1:0] res_cycles;
    logic [RUN_W-1:0]   res_run_idx;

    modport master (
        output start_port, input done_port, input compare_ok,
        output res_valid, input res_ready,
        output res_status, output res_cycles, output res_run_idx
    );

    modport slave (
        input start_port, output done_port, output compare_ok,
        input res_valid, output res_ready,
        input res_status, input res_cycles, input res_run_idx
    );
endinterface

// File: rtl/kernel_run_sequencer.sv
// rtl/kernel_run_sequencer.sv - back-to-back kernel runs with latency, watchdog and result FIFO
// Optional run statistics outputs (stat_min/stat_max/stat_total) under `define RUN_STATS_EN.
module kernel_run_sequencer #(
    parameter int RUN_W     = 8,
    parameter int CYCLE_W   = 32,
    parameter int TIMEOUT   = 200000000,
    parameter int RES_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cfg_start,
    input  logic [RUN_W-1:0]       cfg_num_runs,
    input  logic                   cfg_compare,
    output logic                   busy,
    output logic                   all_done,
    output logic                   timeout_flag,
    kernel_run_sequencer_if.master io
`ifdef RUN_STATS_EN
    ,
    output logic [CYCLE_W-1:0]       stat_min,
    output logic [CYCLE_W-1:0]       stat_max,
    output logic [CYCLE_W+RUN_W-1:0] stat_total
`endif
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_RECORD = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam logic [1:0] ST_FAIL    = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_NOCHECK = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    localparam int AW = $clog2(RES_DEPTH);
    localparam int EW = 2 + CYCLE_W + RUN_W;
    localparam logic [CYCLE_W-1:0] TMO     = CYCLE_W'(TIMEOUT);
    localparam logic [AW:0]        DEPTH_C = (AW+1)'(RES_DEPTH);

    logic [2:0]         state;
    logic [RUN_W-1:0]   num_runs, run_idx;
    logic               compare_en, aborted, rec_pushed, last_run;
    logic [CYCLE_W-1:0] cnt, cnt_inc, rec_cycles;
    logic [1:0]         rec_status, done_status;

    logic [EW-1:0]      mem [RES_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count, count_next;
    logic               full, push, pop;

    assign cnt_inc     = cnt + CYCLE_W'(1);
    assign done_status = compare_en ? (io.compare_ok ? ST_PASS : ST_FAIL) : ST_NOCHECK;
    assign last_run    = aborted || (run_idx == num_runs - RUN_W'(1));

    assign full = (count == DEPTH_C);
    assign pop  = io.res_valid & io.res_ready;
    // A full FIFO still accepts the record when the consumer pops in the same cycle.
    assign push = (state == S_RECORD) && !rec_pushed && (!full || pop);

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + (AW+1)'(1);
        else if (pop && !push) count_next = count - (AW+1)'(1);
    end

    assign busy          = (state != S_IDLE);
    assign io.start_port = (state == S_LAUNCH);
    assign io.res_valid  = (count != '0);
    assign {io.res_status, io.res_cycles, io.res_run_idx} = io.res_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            num_runs     <= '0;
            run_idx      <= '0;
            compare_en   <= 1'b0;
            aborted      <= 1'b0;
            rec_pushed   <= 1'b0;
            cnt          <= '0;
            rec_cycles   <= '0;
            rec_status   <= ST_FAIL;
            timeout_flag <= 1'b0;
            all_done     <= 1'b0;
        end else begin
            all_done <= (state == S_FINISH);
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        num_runs     <= cfg_num_runs;
                        compare_en   <= cfg_compare;
                        run_idx      <= '0;
                        aborted      <= 1'b0;
                        timeout_flag <= 1'b0;
                        state        <= (cfg_num_runs == '0) ? S_FINISH : S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt <= CYCLE_W'(1);
                    if (io.done_port) begin
                        rec_cycles <= CYCLE_W'(1);
                        rec_status <= done_status;
                        state      <= S_RECORD;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // cnt_inc is this cycle's latency; done takes priority over expiry.
                    cnt <= cnt_inc;
                    if (io.done_port) begin
                        rec_cycles <= cnt_inc;
                        rec_status <= done_status;
                        state      <= S_RECORD;
                    end else if (cnt_inc == TMO) begin
                        rec_cycles   <= TMO;
                        rec_status   <= ST_TIMEOUT;
                        timeout_flag <= 1'b1;
                        aborted      <= 1'b1;
                        state        <= S_RECORD;
                    end
                end
                S_RECORD: begin
                    // Hold here after the push until there is room for the next run's record.
                    if (push || rec_pushed) begin
                        if (last_run) begin
                            rec_pushed <= 1'b0;
                            state      <= S_FINISH;
                        end else if (count_next != DEPTH_C) begin
                            rec_pushed <= 1'b0;
                            run_idx    <= run_idx + RUN_W'(1);
                            state      <= S_LAUNCH;
                        end else begin
                            rec_pushed <= 1'b1;
                        end
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {rec_status, rec_cycles, run_idx};
    end

`ifdef RUN_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_min   <= '0;
            stat_max   <= '0;
            stat_total <= '0;
        end else if (state == S_IDLE && cfg_start) begin
            stat_min   <= '1;
            stat_max   <= '0;
            stat_total <= '0;
        end else if (push && rec_status != ST_TIMEOUT) begin
            if (rec_cycles < stat_min) stat_min <= rec_cycles;
            if (rec_cycles > stat_max) stat_max <= rec_cycles;
            stat_total <= stat_total + (CYCLE_W+RUN_W)'(rec_cycles);
        end
    end
`endif
endmodule

// File: tb/tb_kernel_run_sequencer.sv
// tb/tb_kernel_run_sequencer.sv - randomized run sequences checked against a record-level model
`timescale 1ns/1ps
module tb_kernel_run_sequencer;
    localparam int RUN_W = 8, CYCLE_W = 32, TMO = 20, DEPTH = 4;
    localparam int NEVER = 100000, MAXE = 4096;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_start = 1'b0;
    logic             cfg_compare = 1'b0;
    logic [RUN_W-1:0] cfg_num_runs = '0;
    logic             busy, all_done, timeout_flag;

    kernel_run_sequencer_if #(.RUN_W(RUN_W), .CYCLE_W(CYCLE_W)) io ();

    kernel_run_sequencer #(
        .RUN_W(RUN_W), .CYCLE_W(CYCLE_W), .TIMEOUT(TMO), .RES_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .cfg_start(cfg_start), .cfg_num_runs(cfg_num_runs),
        .cfg_compare(cfg_compare), .busy(busy), .all_done(all_done),
        .timeout_flag(timeout_flag), .io(io)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int          checks = 0, errors = 0;
    int          plan_d [256];
    bit          plan_ok [256];
    int          seq_id = 0;
    logic [41:0] exp_rec [MAXE];
    logic [41:0] act_rec [MAXE];
    int          exp_wr = 0, exp_rd = 0, pop_cnt = 0;
    int          launch_cnt = 0, done_cnt = 0, done_cyc = 0, last_start = -100;
    int          ready_mode = 2;
    int          exp_launch = 0, seq_l0 = 0, seq_d0 = 0, seq_p0 = 0, s_cyc = 0;
    bit          exp_to = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic push_exp(input int st, input int cy, input int ix);
        exp_rec[exp_wr] = {2'(st), 32'(cy), 8'(ix)};
        exp_wr++;
    endtask

    // Record-level model: run i finishes after plan_d[i]+1 cycles unless that exceeds the watchdog.
    task automatic start_seq(input int n, input bit cmp);
        exp_launch = 0;
        exp_to     = 1'b0;
        for (int i = 0; i < n; i++) begin
            exp_launch++;
            if (plan_d[i] + 1 > TMO) begin
                push_exp(3, TMO, i);
                exp_to = 1'b1;
                break;
            end
            push_exp(cmp ? (plan_ok[i] ? 1 : 0) : 2, plan_d[i] + 1, i);
        end
        seq_id++;
        seq_l0 = launch_cnt;
        seq_d0 = done_cnt;
        seq_p0 = pop_cnt;
        cfg_start    = 1'b1;
        cfg_num_runs = RUN_W'(n);
        cfg_compare  = cmp;
        s_cyc        = cyc;
        step(1);
        cfg_start    = 1'b0;
        cfg_num_runs = RUN_W'($urandom);
        cfg_compare  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input string name, input int bound);
        int n = 0;
        while (done_cnt == seq_d0 && n < bound) begin
            step(1);
            n++;
        end
        step(3);
        chk({name, "_all_done_once"}, 64'(done_cnt - seq_d0), 64'd1);
        chk({name, "_idle"}, 64'(busy), 64'd0);
        chk({name, "_launches"}, 64'(launch_cnt - seq_l0), 64'(exp_launch));
        chk({name, "_timeout_flag"}, 64'(timeout_flag), 64'(exp_to));
    endtask

    task automatic set_plan(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            plan_d[i]  = d;
            plan_ok[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Kernel stand-in: answers each start_port with done after the planned delay.
    initial begin
        int my_seq, ridx, done_at;
        bit pend, pok;
        my_seq = 0; ridx = 0; done_at = 0; pend = 1'b0; pok = 1'b0;
        io.done_port  = 1'b0;
        io.compare_ok = 1'b0;
        forever begin
            @(negedge clock);
            io.done_port  = 1'b0;
            io.compare_ok = 1'($urandom_range(0, 1));
            if (!reset) begin
                pend = 1'b0;
            end else begin
                if (seq_id != my_seq) begin
                    my_seq = seq_id;
                    ridx   = 0;
                end
                if (io.start_port) begin
                    if (ridx < 256 && plan_d[ridx] < NEVER) begin
                        pend    = 1'b1;
                        done_at = cyc + plan_d[ridx];
                        pok     = plan_ok[ridx];
                    end else begin
                        pend = 1'b0;
                    end
                    ridx++;
                end
                if (pend && cyc == done_at) begin
                    io.done_port  = 1'b1;
                    io.compare_ok = pok;
                    pend          = 1'b0;
                end
            end
        end
    end

    // Consumer and per-cycle compare against the expected record queue.
    initial begin
        io.res_ready = 1'b0;
        forever begin
            @(negedge clock);
            io.res_ready = (ready_mode == 2) ? 1'b1 :
                           (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!reset) begin
                exp_rd     = exp_wr;
                last_start = -100;
            end else begin
                if (io.start_port) begin
                    chk("start_gap", 64'(cyc - last_start >= 2), 64'd1);
                    last_start = cyc;
                    launch_cnt++;
                end
                if (all_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (io.res_valid && io.res_ready) begin
                    act_rec[pop_cnt] = {io.res_status, io.res_cycles, io.res_run_idx};
                    chk("record_expected", 64'(exp_wr > exp_rd), 64'd1);
                    if (exp_wr > exp_rd) begin
                        chk("record", 64'(act_rec[pop_cnt]), 64'(exp_rec[exp_rd]));
                        exp_rd++;
                    end
                    pop_cnt++;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        bit cmp;
        set_plan(NEVER, 256);
        step(3);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_all_done", 64'(all_done), 64'd0);
        chk("rst_timeout_flag", 64'(timeout_flag), 64'd0);
        chk("rst_start_port", 64'(io.start_port), 64'd0);
        chk("rst_res_valid", 64'(io.res_valid), 64'd0);
        chk("rst_res_fields", 64'({io.res_status, io.res_cycles, io.res_run_idx}), 64'd0);
        reset = 1'b1;
        step(2);

        // Three runs, 10-cycle latency, PASS/FAIL/PASS
        ready_mode = 2;
        set_plan(9, 3);
        plan_ok[0] = 1'b1; plan_ok[1] = 1'b0; plan_ok[2] = 1'b1;
        start_seq(3, 1'b1);
        wait_done("A", 500);
        chk("A_pops", 64'(pop_cnt - seq_p0), 64'd3);
        chk("A_rec0", 64'(act_rec[seq_p0]),     64'({2'd1, 32'd10, 8'd0}));
        chk("A_rec1", 64'(act_rec[seq_p0 + 1]), 64'({2'd0, 32'd10, 8'd1}));
        chk("A_rec2", 64'(act_rec[seq_p0 + 2]), 64'({2'd1, 32'd10, 8'd2}));

        // Zero runs
        step(4);
        start_seq(0, 1'b1);
        wait_done("B", 50);
        chk("B_done_latency", 64'(done_cyc - s_cyc), 64'd2);
        chk("B_pops", 64'(pop_cnt - seq_p0), 64'd0);

        // Kernel never answers: one TIMEOUT record, sequence aborted
        step(4);
        set_plan(NEVER, 5);
        start_seq(5, 1'b1);
        wait_done("C", 300);
        chk("C_pops", 64'(pop_cnt - seq_p0), 64'd1);
        chk("C_rec0", 64'(act_rec[seq_p0]), 64'({2'd3, 32'd20, 8'd0}));

        // Done in LAUNCH cycle, then done exactly at the watchdog limit
        step(10);
        plan_d[0] = 0; plan_d[1] = TMO - 1;
        start_seq(2, 1'b0);
        wait_done("D", 300);
        chk("D_rec0", 64'(act_rec[seq_p0]),     64'({2'd2, 32'd1, 8'd0}));
        chk("D_rec1", 64'(act_rec[seq_p0 + 1]), 64'({2'd2, 32'd20, 8'd1}));

        // FIFO back-pressure: four buffered records block the fifth launch
        step(4);
        ready_mode = 0;
        set_plan(2, 6);
        start_seq(6, 1'b1);
        step(80);
        chk("E_launches_blocked", 64'(launch_cnt - seq_l0), 64'd4);
        chk("E_res_valid", 64'(io.res_valid), 64'd1);
        chk("E_busy", 64'(busy), 64'd1);
        chk("E_no_pops", 64'(pop_cnt - seq_p0), 64'd0);
        ready_mode = 2;
        wait_done("E", 800);
        chk("E_pops", 64'(pop_cnt - seq_p0), 64'd6);
        for (int i = 0; i < 6; i++) chk("E_idx_order", 64'(act_rec[seq_p0 + i][7:0]), 64'(i));

        // Reset mid-WAIT with a record still buffered
        step(4);
        ready_mode = 0;
        set_plan(2, 3);
        plan_d[1] = 15;
        start_seq(3, 1'b1);
        n = 0;
        while (launch_cnt - seq_l0 < 2 && n < 200) begin step(1); n++; end
        step(5);
        chk("F_pre_busy", 64'(busy), 64'd1);
        chk("F_pre_res_valid", 64'(io.res_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk("F_rst_start_port", 64'(io.start_port), 64'd0);
        chk("F_rst_busy", 64'(busy), 64'd0);
        chk("F_rst_res_valid", 64'(io.res_valid), 64'd0);
        step(3);
        reset = 1'b1;
        step(2);
        ready_mode = 2;
        set_plan(4, 2);
        start_seq(2, 1'b0);
        wait_done("F", 300);
        chk("F_rec0", 64'(act_rec[seq_p0]),     64'({2'd2, 32'd5, 8'd0}));
        chk("F_rec1", 64'(act_rec[seq_p0 + 1]), 64'({2'd2, 32'd5, 8'd1}));

        // Reset while start_port is high drops it without waiting for a clock
        step(4);
        set_plan(NEVER, 1);
        start_seq(1, 1'b1);
        n = 0;
        while (!io.start_port && n < 20) begin step(1); n++; end
        chk("G_start_seen", 64'(io.start_port), 64'd1);
        reset = 1'b0;
        #1;
        chk("G_rst_start_port", 64'(io.start_port), 64'd0);
        step(3);
        reset = 1'b1;
        step(2);

        // Randomized sequences with random consumer back-pressure
        ready_mode = 1;
        for (int s = 0; s < 40; s++) begin
            n   = $urandom_range(0, 6);
            cmp = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                int r;
                r = $urandom_range(0, 9);
                plan_d[i]  = (r < 6) ? $urandom_range(0, 6) :
                             (r < 8) ? $urandom_range(15, 19) : $urandom_range(18, 25);
                plan_ok[i] = 1'($urandom_range(0, 1));
            end
            start_seq(n, cmp);
            wait_done("R", 2000);
            step($urandom_range(8, 12));
        end

        ready_mode = 2;
        step(20);
        chk("drain_model_empty", 64'(exp_wr - exp_rd), 64'd0);
        chk("drain_res_valid", 64'(io.res_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
